// File: rtl/lighthouse_frame_assembler.sv
// Gathers per-sensor lighthouse sweep words into one 8-slot frame and pulses dataReady
// for the downstream SPI byte sequencer. Frames are sent on a full refresh or a timeout, with an inter-frame holdoff.
module lighthouse_frame_assembler #(
    parameter int NUM_SENSORS    = 8,
    parameter int TIMEOUT_CYCLES = 500000,
    parameter int MIN_GAP_CYCLES = 2048
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      enable,
    input  logic                      sensor_valid,
    input  logic [2:0]                sensor_id,
    input  logic [31:0]               sensor_word,
    output logic [32*NUM_SENSORS-1:0] data,
    output logic                      dataReady,
    output logic [15:0]               frame_count,
    output logic [15:0]               overrun_count,
    output logic                      fsm_state
);
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int GW = (MIN_GAP_CYCLES > 1) ? $clog2(MIN_GAP_CYCLES) : 1;
    localparam logic [TW-1:0] TIMER_MAX = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [GW-1:0] GAP_MAX   = GW'(MIN_GAP_CYCLES - 1);

    typedef enum logic {
        COLLECT = 1'b0,
        HOLDOFF = 1'b1
    } state_t;

    state_t                 state;
    state_t                 state_next;
    logic                   emit;
    logic [30:0]            shadow [NUM_SENSORS];
    logic [NUM_SENSORS-1:0] mask;
    logic [NUM_SENSORS-1:0] wr_hit;
    logic [TW-1:0]          timer;
    logic [GW-1:0]          gap;
    logic                   timer_expired;
    logic                   overrun;
    logic                   unused_word_msb;

    assign unused_word_msb = sensor_word[31];
    assign fsm_state       = state;

    // Ids beyond the slot count match no slot, so such writes are silently dropped.
    always_comb begin
        wr_hit = '0;
        for (int i = 0; i < NUM_SENSORS; i++) begin
            wr_hit[i] = sensor_valid && (32'(sensor_id) == i);
        end
    end

    assign timer_expired = (mask != '0) && (timer == TIMER_MAX);
    // A write on the emit cycle starts the next frame, so it is never an overrun.
    assign overrun       = (|(wr_hit & mask)) && !emit;

    always_comb begin
        state_next = state;
        emit       = 1'b0;
        case (state)
            COLLECT: begin
                if (enable && ((&mask) || timer_expired)) begin
                    emit       = 1'b1;
                    state_next = HOLDOFF;
                end
            end
            HOLDOFF: begin
                if (gap == '0) begin
                    state_next = COLLECT;
                end
            end
            default: state_next = COLLECT;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= COLLECT;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_SENSORS; i++) begin
                shadow[i] <= '0;
            end
            mask          <= '0;
            timer         <= '0;
            gap           <= '0;
            data          <= '0;
            dataReady     <= 1'b0;
            frame_count   <= '0;
            overrun_count <= '0;
        end else begin
            dataReady <= emit;
            if (emit) begin
                // Bit 31 of each slot flags whether it was refreshed in this frame.
                for (int i = 0; i < NUM_SENSORS; i++) begin
                    data[32*i +: 32] <= {mask[i], shadow[i]};
                end
                frame_count <= frame_count + 16'd1;
                mask        <= wr_hit;
                timer       <= '0;
                gap         <= GAP_MAX;
            end else begin
                mask <= mask | wr_hit;
                if ((mask != '0) && (timer != TIMER_MAX)) begin
                    timer <= timer + 1'b1;
                end
                if ((state == HOLDOFF) && (gap != '0)) begin
                    gap <= gap - 1'b1;
                end
            end
            for (int i = 0; i < NUM_SENSORS; i++) begin
                if (wr_hit[i]) begin
                    shadow[i] <= sensor_word[30:0];
                end
            end
            if (overrun && (overrun_count != 16'hFFFF)) begin
                overrun_count <= overrun_count + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_lighthouse_frame_assembler.sv
// Directed bench for lighthouse_frame_assembler: expected frames, counters and pulse
// cycles are queued by the driver and checked by an independent monitor on each dataReady.
module tb_lighthouse_frame_assembler;
    localparam int T = 64;
    localparam int G = 16;
    localparam int W = 320;

    logic         clock = 1'b0;
    logic         reset;
    logic         enable;
    logic         sensor_valid;
    logic [2:0]   sensor_id;
    logic [31:0]  sensor_word;
    logic [255:0] data;
    logic         dataReady;
    logic [15:0]  frame_count;
    logic [15:0]  overrun_count;
    logic         fsm_state;

    int           total = 0;
    int           bad = 0;
    int           cyc = 0;
    int           m;
    int           e;
    int           k;
    logic [255:0] f;
    logic [W-1:0] mon_e;
    logic [W-1:0] exp_q[$];

    lighthouse_frame_assembler #(
        .NUM_SENSORS   (8),
        .TIMEOUT_CYCLES(T),
        .MIN_GAP_CYCLES(G)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .enable       (enable),
        .sensor_valid (sensor_valid),
        .sensor_id    (sensor_id),
        .sensor_word  (sensor_word),
        .data         (data),
        .dataReady    (dataReady),
        .frame_count  (frame_count),
        .overrun_count(overrun_count),
        .fsm_state    (fsm_state)
    );

    // Clock and cycle counter; inputs change and outputs are sampled on the falling edge.
    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation still running, required completion");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1);
    end

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h required %0h", name, act, req);
        end
    endtask

    function automatic logic [255:0] seq_frame(input logic [31:0] base, input logic fresh);
        logic [255:0] r;
        r = '0;
        for (int i = 0; i < 8; i++) begin
            r[32*i +: 32] = {fresh, base[30:0] + 31'(i)};
        end
        return r;
    endfunction

    task automatic push_exp(input int at, input logic [15:0] fc, input logic [15:0] oc,
                            input logic [255:0] fr);
        exp_q.push_back({32'(at), fc, oc, fr});
    endtask

    task automatic wr(input int id, input logic [31:0] w);
        sensor_valid = 1'b1;
        sensor_id    = id[2:0];
        sensor_word  = w;
        @(negedge clock);
        sensor_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic wait_drain(input int budget);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(negedge clock);
            n++;
        end
        if (exp_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain_timeout: %0d frames outstanding, required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic check_reset_outputs();
        check("rst_data", data, 256'd0);
        check("rst_dataReady", 256'(dataReady), 256'd0);
        check("rst_frame_count", 256'(frame_count), 256'd0);
        check("rst_overrun_count", 256'(overrun_count), 256'd0);
        check("rst_fsm_state", 256'(fsm_state), 256'd0);
    endtask

    // Scoreboard monitor: every dataReady pulse must match the oldest expected frame.
    always @(negedge clock) begin
        if (!reset && dataReady) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_pulse: got dataReady=1 at cycle %0d, required no pulse", cyc);
            end else begin
                mon_e = exp_q.pop_front();
                check("pulse_cycle", 256'(cyc), 256'(mon_e[319:288]));
                check("frame_count", 256'(frame_count), 256'(mon_e[287:272]));
                check("overrun_count", 256'(overrun_count), 256'(mon_e[271:256]));
                check("frame_data", data, mon_e[255:0]);
            end
        end
    end

    initial begin
        reset        = 1'b1;
        enable       = 1'b0;
        sensor_valid = 1'b0;
        sensor_id    = 3'd0;
        sensor_word  = 32'd0;
        idle(3);
        check_reset_outputs();
        reset  = 1'b0;
        enable = 1'b1;
        idle(1);

        // Frame with an overrun, then reset in the middle of holdoff with a partial frame.
        m = cyc;
        f = seq_frame(32'hA0, 1'b1);
        f[31:0] = 32'h800000A1;
        push_exp(m + 10, 16'd1, 16'd1, f);
        wr(0, 32'hA0);
        wr(0, 32'hA1);
        for (int i = 1; i < 8; i++) wr(i, 32'hA0 + 32'(i));
        wait_drain(50);
        wr(4, 32'h55);
        wr(5, 32'h66);
        reset = 1'b1;
        idle(1);
        check_reset_outputs();
        idle(1);
        check_reset_outputs();
        reset = 1'b0;
        idle(1);

        // Full refresh on consecutive cycles: pulse two cycles after the last write.
        m = cyc;
        push_exp(m + 9, 16'd1, 16'd0, seq_frame(32'h1000, 1'b1));
        for (int i = 0; i < 8; i++) wr(i, 32'h1000 + 32'(i));
        wait_drain(50);
        idle(G + 5);

        // Single write, timeout-forced frame; other slots repeat stale values.
        m = cyc;
        f = seq_frame(32'h1000, 1'b0);
        f[127:96] = 32'hFFFFFFFF;
        push_exp(m + T + 1, 16'd2, 16'd0, f);
        wr(3, 32'h7FFFFFFF);
        wait_drain(T + 20);
        idle(G + 5);

        // Rewrite of slot 5 before emit: last value wins.
        m = cyc;
        f = seq_frame(32'h2000, 1'b1);
        f[191:160] = 32'h80000022;
        push_exp(m + 10, 16'd3, 16'd1, f);
        wr(5, 32'h11);
        wr(5, 32'h22);
        for (int i = 0; i < 8; i++) if (i != 5) wr(i, 32'h2000 + 32'(i));
        wait_drain(50);
        idle(G + 5);

        // Second full frame collected during holdoff: pulses exactly G+1 cycles apart.
        m = cyc;
        push_exp(m + 9, 16'd4, 16'd1, seq_frame(32'h3000, 1'b1));
        push_exp(m + 9 + G + 1, 16'd5, 16'd1, seq_frame(32'h4000, 1'b1));
        for (int i = 0; i < 8; i++) wr(i, 32'h3000 + 32'(i));
        idle(1);
        for (int i = 0; i < 8; i++) wr(i, 32'h4000 + 32'(i));
        wait_drain(G + 40);
        idle(G + 5);

        // Write on the emit cycle goes to the next frame; enable gates emission.
        m = cyc;
        f = seq_frame(32'h5000, 1'b1);
        f[95:64] = 32'h00004002;
        push_exp(m + T + 1, 16'd6, 16'd1, f);
        for (int i = 0; i < 8; i++) if (i != 2) wr(i, 32'h5000 + 32'(i));
        k = 0;
        while (cyc < m + T && k < 2 * T) begin
            @(negedge clock);
            k++;
        end
        wr(2, 32'h6002);
        enable = 1'b0;
        for (int i = 0; i < 8; i++) if (i != 2) wr(i, 32'h7000 + 32'(i));
        idle(40);
        check("no_pulse_while_disabled", 256'(frame_count), 256'd6);
        e = cyc;
        f = seq_frame(32'h7000, 1'b1);
        f[95:64] = 32'h80006002;
        push_exp(e + 1, 16'd7, 16'd1, f);
        enable = 1'b1;
        wait_drain(20);
        idle(5);
        check("queue_empty", 256'(exp_q.size()), 256'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
